pool2_sched: RTL and testbench

- Time-multiplexed controller for layer-2 binary max-pooling: 60 channels of 8x8 1-bit fmaps become 60 channels of 4x4.
- Replaces 60 parallel pooling channels with LANES shared 2x2 pool lanes, sequenced over ceil(NUM_CH/LANES) cycles.
- Sits between conv2 output and the flatten/FC stage, with valid/ready handshakes on both sides.

---
 rtl/pool2_sched_if.sv | 33 +++
 rtl/pool2_sched.sv | 154 +++++++++++++++
 tb/tb_pool2_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool2_sched_if.sv
// Frame handshake bundle for pool2_sched: 8x8 binary fmaps in, pooled 4x4 fmaps out,
// each direction with its own valid/ready pair.
interface pool2_sched_if #(
  parameter int NUM_CH = 60,
  parameter int IN_DIM = 8
);
  localparam int OUT_DIM = IN_DIM / 2;

  logic                                in_valid;
  logic                                in_ready;
  logic [0:NUM_CH*IN_DIM*IN_DIM-1]     fmaps_in;
  logic                                out_valid;
  logic                                out_ready;
  logic [0:NUM_CH*OUT_DIM*OUT_DIM-1]   fmaps_out;

  modport master (
    output in_valid,
    output fmaps_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  fmaps_out
  );

  modport slave (
    input  in_valid,
    input  fmaps_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output fmaps_out
  );
endinterface

// File: rtl/pool2_sched.sv
// Time-multiplexed 2x2 binary max-pool: LANES shared lanes sweep NUM_CH channels
// in NGRP groups from a captured input frame into a held output buffer.
module pool2_sched #(
  parameter  int NUM_CH = 60,
  parameter  int IN_DIM = 8,
  parameter  int LANES  = 4,
  localparam int NGRP   = (NUM_CH + LANES - 1) / LANES,
  localparam int GIW    = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic           clk,
  input  logic           rst,
  pool2_sched_if.slave   bus,
  output logic           busy,
  output logic [GIW-1:0] grp_idx
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int ISZ     = IN_DIM * IN_DIM;
  localparam int OSZ     = OUT_DIM * OUT_DIM;
  localparam int IBITS   = NUM_CH * ISZ;
  localparam int OBITS   = NUM_CH * OSZ;
  localparam int IIW     = (IBITS > 1) ? $clog2(IBITS) : 1;
  localparam int OIW     = (OBITS > 1) ? $clog2(OBITS) : 1;
  localparam int SIW     = (OSZ > 1) ? $clog2(OSZ) : 1;
  localparam int CIW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GIW-1:0] LAST_GRP = GIW'(NGRP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [GIW-1:0]   grp_idx_r, grp_idx_s;
  logic             out_valid_r, out_valid_s;
  logic             accept_s, run_s;
  logic [0:IBITS-1] ibuf_r;
  logic [0:OBITS-1] obuf_r;

  logic [LANES-1:0] lane_act_s;
  logic [CIW-1:0]   lane_ch_s   [LANES];
  logic [0:OSZ-1]   lane_pool_s [LANES];

  // 2x2 OR-reduction of one channel of the frame; ch must already be in range.
  function automatic logic [0:OSZ-1] pool_ch(input logic [0:IBITS-1] frame,
                                             input logic [CIW-1:0]   ch);
    logic [0:OSZ-1] res;
    int             px;
    res = '0;
    for (int r = 0; r < OUT_DIM; r++) begin
      for (int k = 0; k < OUT_DIM; k++) begin
        px = int'(ch) * ISZ + 2 * r * IN_DIM + 2 * k;
        res[SIW'(r * OUT_DIM + k)] = frame[IIW'(px)]          | frame[IIW'(px + 1)] |
                                     frame[IIW'(px + IN_DIM)] | frame[IIW'(px + IN_DIM + 1)];
      end
    end
    return res;
  endfunction

  // Lane-to-channel mapping; inactive tail lanes are parked on channel 0 and never written back.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_act_s[l] = (int'(grp_idx_r) * LANES + l) < NUM_CH;
      if (lane_act_s[l]) begin
        lane_ch_s[l] = CIW'(int'(grp_idx_r) * LANES + l);
      end else begin
        lane_ch_s[l] = '0;
      end
      lane_pool_s[l] = pool_ch(ibuf_r, lane_ch_s[l]);
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_s     = state_r;
    grp_idx_s   = grp_idx_r;
    out_valid_s = out_valid_r;
    accept_s    = 1'b0;
    run_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_s  = 1'b1;
          grp_idx_s = '0;
          state_s   = ST_RUN;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        run_s = 1'b1;
        if (grp_idx_r == LAST_GRP) begin
          state_s     = ST_DONE;
          out_valid_s = 1'b1;
        end else begin
          grp_idx_s   = grp_idx_r + GIW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_s = 1'b0;
          grp_idx_s   = '0;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        grp_idx_s   = '0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      grp_idx_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      grp_idx_r   <= grp_idx_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Frame capture and per-lane write-back into the output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_r <= '0;
      obuf_r <= '0;
    end else begin
      if (accept_s) begin
        ibuf_r <= bus.fmaps_in;
      end
      if (run_s) begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_act_s[l]) begin
            obuf_r[OIW'(int'(lane_ch_s[l]) * OSZ) +: OSZ] <= lane_pool_s[l];
          end
        end
      end
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.fmaps_out = obuf_r;
  assign busy          = (state_r != ST_IDLE);
  assign grp_idx       = grp_idx_r;

endmodule

// File: tb/tb_pool2_sched.sv
// Directed bench for pool2_sched: default LANES=4 instance plus LANES=7 and LANES=60
// instances sharing clock and reset, checked against an independent OR-pool model.
module tb_pool2_sched;
  localparam int NC    = 60;
  localparam int ID    = 8;
  localparam int OD    = ID / 2;
  localparam int ISZ   = ID * ID;
  localparam int OSZ   = OD * OD;
  localparam int IB    = NC * ISZ;
  localparam int OB    = NC * OSZ;
  localparam int NGRP4 = 15;

  typedef logic [0:IB-1] frame_t;
  typedef logic [0:OB-1] pooled_t;

  logic       clk;
  logic       rst;
  logic       busy4, busy7, busy60;
  logic [3:0] grp4, grp7;
  logic [0:0] grp60;
  int         n_cmp;
  int         n_bad;

  pool2_sched_if #(.NUM_CH(NC), .IN_DIM(ID)) b4 ();
  pool2_sched_if #(.NUM_CH(NC), .IN_DIM(ID)) b7 ();
  pool2_sched_if #(.NUM_CH(NC), .IN_DIM(ID)) b60 ();

  pool2_sched #(.NUM_CH(NC), .IN_DIM(ID), .LANES(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4), .busy(busy4), .grp_idx(grp4));
  pool2_sched #(.NUM_CH(NC), .IN_DIM(ID), .LANES(7)) u7 (
    .clk(clk), .rst(rst), .bus(b7), .busy(busy7), .grp_idx(grp7));
  pool2_sched #(.NUM_CH(NC), .IN_DIM(ID), .LANES(60)) u60 (
    .clk(clk), .rst(rst), .bus(b60), .busy(busy60), .grp_idx(grp60));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each output pixel is the OR of its 2x2 input window.
  function automatic pooled_t model_pool(input frame_t f);
    pooled_t o;
    logic    v;
    o = '0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < OD; r++) begin
        for (int k = 0; k < OD; k++) begin
          v = 1'b0;
          for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
              v = v | f[c * ISZ + (2 * r + dy) * ID + 2 * k + dx];
            end
          end
          o[c * OSZ + r * OD + k] = v;
        end
      end
    end
    return o;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < IB / 32; i++) begin
      f[i * 32 +: 32] = $urandom();
    end
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid on the LANES=4 instance; lat counts edges after the accept edge.
  task automatic wait_out4(input int limit, output int lat, output pooled_t got);
    lat = -1;
    got = '0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (b4.out_valid === 1'b1) begin
        lat = i;
        got = b4.fmaps_out;
        break;
      end
    end
  endtask

  task automatic accept4(input frame_t f);
    b4.fmaps_in = f;
    b4.in_valid = 1'b1;
    step();
    b4.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (b4.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", b4.in_ready); end
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", b4.out_valid); end
    n_cmp++; if (b4.fmaps_out !== '0) begin n_bad++; $display("FAIL reset_fmaps_out: got %h want 0", b4.fmaps_out); end
    n_cmp++; if (b7.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid7: got %b want 0", b7.out_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %b want 1", b4.in_ready); end
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy4); end
    n_cmp++; if (grp4 !== 4'd0) begin n_bad++; $display("FAIL idle_grp_idx: got %0d want 0", grp4); end
  endtask

  task automatic test_single_pixel();
    frame_t  f;
    pooled_t exp_o;
    pooled_t got;
    int      lat;
    f     = '0;
    f[37 * 64 + 5 * 8 + 2] = 1'b1;
    exp_o = '0;
    exp_o[37 * 16 + 2 * 4 + 1] = 1'b1;
    b4.out_ready = 1'b1;
    accept4(f);
    b4.fmaps_in = '1;
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy4); end
    n_cmp++; if (b4.in_ready !== 1'b0) begin n_bad++; $display("FAIL single_in_ready_run: got %b want 0", b4.in_ready); end
    wait_out4(40, lat, got);
    n_cmp++; if (lat !== NGRP4) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", lat, NGRP4); end
    n_cmp++; if (got !== exp_o) begin n_bad++; $display("FAIL single_result: got %h want %h", got, exp_o); end
    step();
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_done_cycle: got %b want 0", b4.out_valid); end
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_bad++; $display("FAIL single_back_idle: got %b want 1", b4.in_ready); end
    b4.out_ready = 1'b0;
  endtask

  task automatic test_full_pattern();
    frame_t  f;
    pooled_t exp_o;
    f     = rand_frame();
    exp_o = model_pool(f);
    b4.out_ready = 1'b0;
    accept4(f);
    for (int g = 0; g < NGRP4; g++) begin
      n_cmp++; if (grp4 !== 4'(g)) begin n_bad++; $display("FAIL full_grp_idx: got %0d want %0d", grp4, g); end
      n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b want 0 at grp %0d", b4.out_valid, g); end
      step();
    end
    n_cmp++; if (b4.out_valid !== 1'b1) begin n_bad++; $display("FAIL full_out_valid: got %b want 1", b4.out_valid); end
    n_cmp++; if (b4.fmaps_out !== exp_o) begin n_bad++; $display("FAIL full_result: got %h want %h", b4.fmaps_out, exp_o); end
    b4.out_ready = 1'b1;
    step();
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL full_release: got busy %b want 0", busy4); end
    b4.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    frame_t  fa, fb;
    pooled_t exp_a, exp_b, got;
    int      lat;
    fa    = rand_frame();
    fb    = rand_frame();
    exp_a = model_pool(fa);
    exp_b = model_pool(fb);
    b4.out_ready = 1'b0;
    accept4(fa);
    wait_out4(40, lat, got);
    n_cmp++; if (got !== exp_a) begin n_bad++; $display("FAIL bp_first_result: got %h want %h", got, exp_a); end
    b4.fmaps_in = fb;
    b4.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (b4.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1 cycle %0d", b4.out_valid, i); end
      n_cmp++; if (b4.fmaps_out !== exp_a) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", b4.fmaps_out, exp_a); end
      n_cmp++; if (b4.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0 cycle %0d", b4.in_ready, i); end
    end
    b4.out_ready = 1'b1;
    step();
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", b4.out_valid); end
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", b4.in_ready); end
    n_cmp++; if (grp4 !== 4'd0) begin n_bad++; $display("FAIL bp_release_grp: got %0d want 0", grp4); end
    step();
    b4.in_valid = 1'b0;
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL bp_second_accept: got busy %b want 1", busy4); end
    wait_out4(40, lat, got);
    n_cmp++; if (lat !== NGRP4) begin n_bad++; $display("FAIL bp_second_latency: got %0d want %0d", lat, NGRP4); end
    n_cmp++; if (got !== exp_b) begin n_bad++; $display("FAIL bp_second_result: got %h want %h", got, exp_b); end
    step();
    b4.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    frame_t  f;
    pooled_t exp_o, got;
    int      lat;
    logic    found;
    f = rand_frame();
    b4.out_ready = 1'b1;
    accept4(f);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (grp4 === 4'd7) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_reach_grp7: got %0d want 7", grp4); end
    rst = 1'b1;
    step();
    n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy4); end
    n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", b4.out_valid); end
    n_cmp++; if (b4.fmaps_out !== '0) begin n_bad++; $display("FAIL mid_fmaps_out: got %h want 0", b4.fmaps_out); end
    n_cmp++; if (grp4 !== 4'd0) begin n_bad++; $display("FAIL mid_grp_idx: got %0d want 0", grp4); end
    n_cmp++; if (b4.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready_rst: got %b want 0", b4.in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (b4.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", b4.in_ready); end
    f     = rand_frame();
    exp_o = model_pool(f);
    accept4(f);
    wait_out4(40, lat, got);
    n_cmp++; if (lat !== NGRP4) begin n_bad++; $display("FAIL mid_after_latency: got %0d want %0d", lat, NGRP4); end
    n_cmp++; if (got !== exp_o) begin n_bad++; $display("FAIL mid_after_result: got %h want %h", got, exp_o); end
    step();
    b4.out_ready = 1'b0;
  endtask

  task automatic test_lane_sweep();
    frame_t  f;
    pooled_t exp_o, got7, got60;
    int      lat7, lat60;
    f     = rand_frame();
    exp_o = model_pool(f);
    b7.fmaps_in   = f;
    b60.fmaps_in  = f;
    b7.out_ready  = 1'b1;
    b60.out_ready = 1'b1;
    b7.in_valid   = 1'b1;
    b60.in_valid  = 1'b1;
    step();
    b7.in_valid  = 1'b0;
    b60.in_valid = 1'b0;
    b7.fmaps_in  = '0;
    b60.fmaps_in = '0;
    lat7  = -1;
    lat60 = -1;
    got7  = '0;
    got60 = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (lat7 < 0 && b7.out_valid === 1'b1) begin
        lat7 = i;
        got7 = b7.fmaps_out;
      end
      if (lat60 < 0 && b60.out_valid === 1'b1) begin
        lat60 = i;
        got60 = b60.fmaps_out;
      end
    end
    n_cmp++; if (lat7 !== 9) begin n_bad++; $display("FAIL lanes7_latency: got %0d want 9", lat7); end
    n_cmp++; if (got7 !== exp_o) begin n_bad++; $display("FAIL lanes7_result: got %h want %h", got7, exp_o); end
    n_cmp++; if (lat60 !== 1) begin n_bad++; $display("FAIL lanes60_latency: got %0d want 1", lat60); end
    n_cmp++; if (got60 !== exp_o) begin n_bad++; $display("FAIL lanes60_result: got %h want %h", got60, exp_o); end
    n_cmp++; if (busy7 !== 1'b0) begin n_bad++; $display("FAIL lanes7_idle: got busy %b want 0", busy7); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    b4.in_valid   = 1'b0; b4.out_ready  = 1'b0; b4.fmaps_in  = '0;
    b7.in_valid   = 1'b0; b7.out_ready  = 1'b0; b7.fmaps_in  = '0;
    b60.in_valid  = 1'b0; b60.out_ready = 1'b0; b60.fmaps_in = '0;
    test_reset();
    test_single_pixel();
    test_full_pattern();
    test_backpressure();
    test_reset_mid();
    test_lane_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
